// File: rtl/riscv_ctrl_pipe.sv
// Registered RV32 control decoder with a multi-cycle multiply stall.
// Also produces rs1/rs2 forwarding selects and GPIO CSR write enables.
module riscv_ctrl_pipe #(
    parameter int          MUL_CYCLES = 3,
    parameter int          NUM_GPIO   = 2,
    parameter logic [11:0] CSR_BASE   = 12'hF02
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instr,
    input  logic                instr_valid,
    output logic                stall,
    output logic [3:0]          aluop,
    output logic                alusrc,
    output logic [1:0]          regsel,
    output logic                regwrite,
    output logic [4:0]          rd,
    output logic [NUM_GPIO-1:0] gpio_we,
    output logic                fwd_a,
    output logic                fwd_b,
    output logic                illegal
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    localparam logic [3:0] A_ADD   = 4'b0000;
    localparam logic [3:0] A_SUB   = 4'b0001;
    localparam logic [3:0] A_AND   = 4'b0010;
    localparam logic [3:0] A_OR    = 4'b0011;
    localparam logic [3:0] A_XOR   = 4'b0100;
    localparam logic [3:0] A_SLL   = 4'b0101;
    localparam logic [3:0] A_SRL   = 4'b0110;
    localparam logic [3:0] A_SRA   = 4'b0111;
    localparam logic [3:0] A_SLT   = 4'b1000;
    localparam logic [3:0] A_SLTU  = 4'b1001;
    localparam logic [3:0] A_MUL   = 4'b1010;
    localparam logic [3:0] A_MULH  = 4'b1011;
    localparam logic [3:0] A_MULHU = 4'b1100;

    typedef struct packed {
        logic [3:0]          aluop;
        logic                alusrc;
        logic [1:0]          regsel;
        logic                rw;
        logic [4:0]          rd;
        logic [NUM_GPIO-1:0] gpio;
        logic                ill;
    } ex_t;

    typedef enum logic {RUN, MULBUSY} state_t;

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    ex_t        ex, ex_nx, dec;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  id_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] csr;
    logic [11:0] csr_off;
    logic        is_r, is_i, is_lui, is_csrrw;
    logic        d_ok, d_mul;
    logic        accept, start_mul;

    assign opcode  = instr[6:0];
    assign id_rd   = instr[11:7];
    assign f3      = instr[14:12];
    assign rs1     = instr[19:15];
    assign rs2     = instr[24:20];
    assign f7      = instr[31:25];
    assign csr     = instr[31:20];
    assign csr_off = csr - CSR_BASE;

    assign is_r     = (opcode == OP_R);
    assign is_i     = (opcode == OP_I);
    assign is_lui   = (opcode == OP_LUI);
    assign is_csrrw = (opcode == OP_SYS) && (f3 == 3'b001);

    always_comb begin
        dec   = '0;
        d_ok  = 1'b0;
        d_mul = 1'b0;
        unique case (1'b1)
            is_r: begin
                dec.regsel = 2'b10;
                dec.rw     = 1'b1;
                d_ok       = 1'b1;
                case ({f7, f3})
                    10'b0000000_000: dec.aluop = A_ADD;
                    10'b0100000_000: dec.aluop = A_SUB;
                    10'b0000000_001: dec.aluop = A_SLL;
                    10'b0000000_010: dec.aluop = A_SLT;
                    10'b0000000_011: dec.aluop = A_SLTU;
                    10'b0000000_100: dec.aluop = A_XOR;
                    10'b0000000_101: dec.aluop = A_SRL;
                    10'b0100000_101: dec.aluop = A_SRA;
                    10'b0000000_110: dec.aluop = A_OR;
                    10'b0000000_111: dec.aluop = A_AND;
                    10'b0000001_000: begin
                        dec.aluop = A_MUL;
                        d_mul     = 1'b1;
                    end
                    10'b0000001_001: begin
                        dec.aluop = A_MULH;
                        d_mul     = 1'b1;
                    end
                    10'b0000001_011: begin
                        dec.aluop = A_MULHU;
                        d_mul     = 1'b1;
                    end
                    default: d_ok = 1'b0;
                endcase
            end
            is_i: begin
                dec.alusrc = 1'b1;
                dec.regsel = 2'b10;
                dec.rw     = 1'b1;
                d_ok       = 1'b1;
                case (f3)
                    3'b000: dec.aluop = A_ADD;
                    3'b010: dec.aluop = A_SLT;
                    3'b011: dec.aluop = A_SLTU;
                    3'b100: dec.aluop = A_XOR;
                    3'b110: dec.aluop = A_OR;
                    3'b111: dec.aluop = A_AND;
                    3'b001: begin
                        dec.aluop = A_SLL;
                        d_ok      = (f7 == 7'b0000000);
                    end
                    default: begin
                        dec.aluop = f7[5] ? A_SRA : A_SRL;
                        d_ok      = (f7 == 7'b0000000)
                                 || (f7 == 7'b0100000);
                    end
                endcase
            end
            is_lui: begin
                dec.regsel = 2'b01;
                dec.rw     = 1'b1;
                d_ok       = 1'b1;
            end
            is_csrrw: begin
                // GPIO input read at F00 wins over an overlapping output window
                if (csr == 12'hF00) begin
                    dec.rw = 1'b1;
                    d_ok   = 1'b1;
                end else if (csr_off < 12'(NUM_GPIO)) begin
                    for (int k = 0; k < NUM_GPIO; k++) begin
                        dec.gpio[k] = (csr_off == 12'(k));
                    end
                    d_ok = 1'b1;
                end
            end
            default: d_ok = 1'b0;
        endcase
        if (d_ok) begin
            dec.rd = id_rd;
            dec.rw = dec.rw && (id_rd != 5'd0);
        end else begin
            dec     = '0;
            dec.ill = 1'b1;
            d_mul   = 1'b0;
        end
    end

    assign accept    = instr_valid && !stall;
    assign start_mul = accept && d_mul && (MUL_CYCLES > 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 4'd0;
            ex    <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            ex    <= ex_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            RUN: begin
                if (start_mul) begin
                    state_nx = MULBUSY;
                    cnt_nx   = 4'(MUL_CYCLES - 1);
                end
            end
            MULBUSY: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nx = RUN;
                end
            end
            default: begin
                state_nx = RUN;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    // The mul stays in EX while busy; its write is released on the last cycle
    always_comb begin
        ex_nx = '0;
        if (state == MULBUSY) begin
            ex_nx = ex;
        end else if (accept) begin
            ex_nx = dec;
        end
    end

    always_comb begin
        stall    = (state == MULBUSY);
        aluop    = ex.aluop;
        alusrc   = ex.alusrc;
        regsel   = ex.regsel;
        regwrite = ex.rw && (state == RUN);
        rd       = ex.rd;
        gpio_we  = ex.gpio;
        illegal  = ex.ill;
        fwd_a    = instr_valid && regwrite && (ex.rd != 5'd0)
                && (rs1 == ex.rd);
        fwd_b    = instr_valid && regwrite && (ex.rd != 5'd0)
                && (rs2 == ex.rd);
    end

endmodule

// File: tb/tb_riscv_ctrl_pipe.sv
// Directed bench for riscv_ctrl_pipe (MUL_CYCLES=3, NUM_GPIO=2).
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_riscv_ctrl_pipe;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic [3:0]  aluop;
    logic        alusrc;
    logic [1:0]  regsel;
    logic        regwrite;
    logic [4:0]  rd;
    logic [1:0]  gpio_we;
    logic        fwd_a;
    logic        fwd_b;
    logic        illegal;

    int checks   = 0;
    int failures = 0;

    riscv_ctrl_pipe #(
        .MUL_CYCLES(3),
        .NUM_GPIO  (2),
        .CSR_BASE  (12'hF02)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .instr_valid(instr_valid),
        .stall      (stall),
        .aluop      (aluop),
        .alusrc     (alusrc),
        .regsel     (regsel),
        .regwrite   (regwrite),
        .rd         (rd),
        .gpio_we    (gpio_we),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] w);
        instr_valid = v;
        instr       = w;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0);
        tick();
        tick();
        chk("rst_stall", 32'(stall), 0);
        chk("rst_regwrite", 32'(regwrite), 0);
        chk("rst_aluop", 32'(aluop), 0);
        chk("rst_rd", 32'(rd), 0);
        chk("rst_gpio", 32'(gpio_we), 0);
        chk("rst_illegal", 32'(illegal), 0);
        rst = 1'b0;

        // add x3,x1,x2 then sub x4,x3,x1
        drive(1'b1, 32'h002081B3);
        tick();
        chk("add_aluop", 32'(aluop), 0);
        chk("add_rw", 32'(regwrite), 1);
        chk("add_rd", 32'(rd), 3);
        chk("add_regsel", 32'(regsel), 2);
        chk("add_alusrc", 32'(alusrc), 0);
        drive(1'b1, 32'h40118233);
        #1;
        chk("sub_fwd_a", 32'(fwd_a), 1);
        chk("sub_fwd_b", 32'(fwd_b), 0);
        tick();
        chk("sub_aluop", 32'(aluop), 1);
        chk("sub_rd", 32'(rd), 4);
        chk("sub_rw", 32'(regwrite), 1);

        // mul x5,x1,x2 followed by add x6,x5,x0
        drive(1'b1, 32'h022082B3);
        tick();
        chk("mul1_stall", 32'(stall), 1);
        chk("mul1_rw", 32'(regwrite), 0);
        chk("mul1_aluop", 32'(aluop), 32'hA);
        chk("mul1_rd", 32'(rd), 5);
        drive(1'b1, 32'h00028333);
        #1;
        chk("mul1_fwd_a", 32'(fwd_a), 0);
        tick();
        chk("mul2_stall", 32'(stall), 1);
        chk("mul2_rw", 32'(regwrite), 0);
        chk("mul2_rd", 32'(rd), 5);
        tick();
        chk("mul3_stall", 32'(stall), 0);
        chk("mul3_rw", 32'(regwrite), 1);
        chk("mul3_rd", 32'(rd), 5);
        chk("mul3_aluop", 32'(aluop), 32'hA);
        chk("mul3_fwd_a", 32'(fwd_a), 1);
        tick();
        chk("after_mul_rd", 32'(rd), 6);
        chk("after_mul_rw", 32'(regwrite), 1);
        chk("after_mul_aluop", 32'(aluop), 0);
        chk("after_mul_stall", 32'(stall), 0);

        // reset in the middle of a multiply
        drive(1'b1, 32'h022082B3);
        tick();
        drive(1'b0, 32'h0);
        tick();
        chk("mb_stall", 32'(stall), 1);
        rst = 1'b1;
        #1;
        chk("arst_stall", 32'(stall), 0);
        chk("arst_rw", 32'(regwrite), 0);
        chk("arst_gpio", 32'(gpio_we), 0);
        chk("arst_aluop", 32'(aluop), 0);
        rst = 1'b0;

        // csrrw x0,0xF03,x6
        drive(1'b1, 32'hF0331073);
        tick();
        chk("gpo_we", 32'(gpio_we), 2);
        chk("gpo_rw", 32'(regwrite), 0);
        chk("gpo_ill", 32'(illegal), 0);
        chk("gpo_stall", 32'(stall), 0);

        // csrrw x7,0xF00,x0
        drive(1'b1, 32'hF00013F3);
        tick();
        chk("gpi_regsel", 32'(regsel), 0);
        chk("gpi_rw", 32'(regwrite), 1);
        chk("gpi_rd", 32'(rd), 7);
        chk("gpi_gpio", 32'(gpio_we), 0);

        // csrrw x0,0xF05,x0 is outside the GPIO window
        drive(1'b1, 32'hF0501073);
        tick();
        chk("csr_ill", 32'(illegal), 1);
        chk("csr_ill_rw", 32'(regwrite), 0);
        chk("csr_ill_gpio", 32'(gpio_we), 0);

        // lw x1,0(x0) is unsupported
        drive(1'b1, 32'h00002083);
        tick();
        chk("lw_ill", 32'(illegal), 1);
        chk("lw_rw", 32'(regwrite), 0);
        chk("lw_gpio", 32'(gpio_we), 0);
        drive(1'b0, 32'h0);
        tick();
        chk("ill_pulse_end", 32'(illegal), 0);

        // lui x8,0x12345
        drive(1'b1, 32'h12345437);
        tick();
        chk("lui_regsel", 32'(regsel), 1);
        chk("lui_rw", 32'(regwrite), 1);
        chk("lui_rd", 32'(rd), 8);
        chk("lui_aluop", 32'(aluop), 0);

        // addi x0,x1,5
        drive(1'b1, 32'h00508013);
        tick();
        chk("addi_x0_rw", 32'(regwrite), 0);
        chk("addi_alusrc", 32'(alusrc), 1);
        chk("addi_ill", 32'(illegal), 0);

        // srai x9,x1,3
        drive(1'b1, 32'h4030D493);
        tick();
        chk("srai_aluop", 32'(aluop), 7);
        chk("srai_alusrc", 32'(alusrc), 1);
        chk("srai_rd", 32'(rd), 9);
        chk("srai_rw", 32'(regwrite), 1);
        drive(1'b0, 32'h0);
        tick();
        chk("bubble_rw", 32'(regwrite), 0);
        chk("bubble_rd", 32'(rd), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
